// File: rtl/serial_add_arb_if.sv
// Request/operand and result channel bundle for serial_add_arb.
// SERIAL_ADD_SUB_EN adds the per-requester subtract selects.
interface serial_add_arb_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ack0;
    logic             ack1;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_tag;
    logic             busy;
`ifdef SERIAL_ADD_SUB_EN
    logic             req0_sub;
    logic             req1_sub;

    modport master (
        output req0, req1, a0, b0, a1, b1, req0_sub, req1_sub, res_ready,
        input  ack0, ack1, res_valid, res_sum, res_cout, res_tag, busy
    );
    modport slave (
        input  req0, req1, a0, b0, a1, b1, req0_sub, req1_sub, res_ready,
        output ack0, ack1, res_valid, res_sum, res_cout, res_tag, busy
    );
`else
    modport master (
        output req0, req1, a0, b0, a1, b1, res_ready,
        input  ack0, ack1, res_valid, res_sum, res_cout, res_tag, busy
    );
    modport slave (
        input  req0, req1, a0, b0, a1, b1, res_ready,
        output ack0, ack1, res_valid, res_sum, res_cout, res_tag, busy
    );
`endif
endinterface

// File: rtl/serial_add_arb.sv
// Two-requester round-robin bit-serial adder sharing one full-adder cell and carry flop.
// Define SERIAL_ADD_SUB_EN to enable per-request subtraction (a - b via ~b and carry-in 1).
module serial_add_arb #(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    serial_add_arb_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic             cout;
    logic             tag;
    logic             last;
    logic [CntW-1:0]  cnt;

    logic             grant0;
    logic             grant1;
    logic             sub0;
    logic             sub1;
    logic             sub_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             s_bit;
    logic             c_bit;

`ifdef SERIAL_ADD_SUB_EN
    assign sub0 = bus.req0_sub;
    assign sub1 = bus.req1_sub;
`else
    assign sub0 = 1'b0;
    assign sub1 = 1'b0;
`endif

    // On a tie the requester not served last wins; last resets to 1 so req0 goes first.
    always_comb begin
        grant0  = bus.req0 & (~bus.req1 | last);
        grant1  = bus.req1 & ~grant0;
        sub_sel = grant1 ? sub1 : sub0;
        a_sel   = grant1 ? bus.a1 : bus.a0;
        b_sel   = (grant1 ? bus.b1 : bus.b0) ^ {WIDTH{sub_sel}};
        s_bit   = a_sr[0] ^ b_sr[0] ^ carry;
        c_bit   = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & carry);
    end

    // Gated by rst so the acks read 0 while reset is held, even with requests pending.
    assign bus.ack0      = ~rst & (state == StIdle) & grant0;
    assign bus.ack1      = ~rst & (state == StIdle) & grant1;
    assign bus.res_valid = (state == StDone);
    assign bus.busy      = (state != StIdle);
    assign bus.res_sum   = sum_sr;
    assign bus.res_cout  = cout;
    assign bus.res_tag   = tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cout   <= 1'b0;
            tag    <= 1'b0;
            last   <= 1'b1;
            cnt    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (grant0 | grant1) begin
                        a_sr  <= a_sel;
                        b_sr  <= b_sel;
                        carry <= sub_sel;
                        cnt   <= '0;
                        tag   <= grant1;
                        last  <= grant1;
                        state <= StRun;
                    end
                end
                StRun: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
                    carry  <= c_bit;
                    cnt    <= cnt + CntW'(1);
                    if (cnt == CntW'(WIDTH - 1)) begin
                        cout  <= c_bit;
                        state <= StDone;
                    end
                end
                StDone: begin
                    if (bus.res_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_arb.sv
// Randomised bench for serial_add_arb: per-requester operation queues drive the DUT and a
// cycle-level reference (arbitration, latency, modular arithmetic) checks every negedge.
module tb_serial_add_arb;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_add_arb_if #(.WIDTH(W)) bus ();
    serial_add_arb #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
    } op_t;

    op_t          q0[$];
    op_t          q1[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    bit           m_active = 0;
    bit           m_last = 1;
    int           m_age = 0;
    logic         m_tag = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    bit           ack0_seen = 0;
    bit           ack1_seen = 0;
    bit           chk_gap = 0;
    int           last_ack_cyc = -1;
    int           n_acks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference result: plain (WIDTH+1)-bit arithmetic, subtraction as a + ~b + 1.
    function automatic logic [W:0] ref_result(input op_t o);
        logic [W-1:0] bb;
        bb = o.sub ? ~o.b : o.b;
        return {1'b0, o.a} + {1'b0, bb} + {{W{1'b0}}, o.sub};
    endfunction

    function automatic op_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        op_t o;
        o.a = a;
        o.b = b;
        o.sub = sub;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.a = W'($urandom);
        o.b = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
        o.sub = 1'($urandom);
`else
        o.sub = 1'b0;
`endif
        return o;
    endfunction

    // Requester side: present the queue head until acked, garbage operands otherwise.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (ack0_seen && q0.size() > 0) void'(q0.pop_front());
            if (ack1_seen && q1.size() > 0) void'(q1.pop_front());
            ack0_seen = 0;
            ack1_seen = 0;
            if (q0.size() > 0) begin
                bus.req0 = 1'b1;
                bus.a0 = q0[0].a;
                bus.b0 = q0[0].b;
            end else begin
                bus.req0 = 1'b0;
                bus.a0 = W'($urandom);
                bus.b0 = W'($urandom);
            end
            if (q1.size() > 0) begin
                bus.req1 = 1'b1;
                bus.a1 = q1[0].a;
                bus.b1 = q1[0].b;
            end else begin
                bus.req1 = 1'b0;
                bus.a1 = W'($urandom);
                bus.b1 = W'($urandom);
            end
`ifdef SERIAL_ADD_SUB_EN
            bus.req0_sub = (q0.size() > 0) ? q0[0].sub : 1'($urandom);
            bus.req1_sub = (q1.size() > 0) ? q1[0].sub : 1'($urandom);
`endif
        end
    end

    // Reference model and checker, evaluated mid-cycle.
    initial begin
        bit   e0;
        bit   e1;
        op_t  o;
        logic [W:0] r;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_out", {bus.ack0, bus.ack1, bus.busy, bus.res_valid, bus.res_cout,
                    bus.res_tag, bus.res_sum}, 32'd0);
                m_active = 0;
                m_last = 1;
            end else if (!m_active) begin
                e0 = bus.req0 && (!bus.req1 || m_last);
                e1 = bus.req1 && !e0;
                chk("ack", {bus.ack1, bus.ack0}, {e1, e0});
                chk("idle_flags", {bus.busy, bus.res_valid}, 32'd0);
                if (bus.ack0) ack0_seen = 1;
                if (bus.ack1) ack1_seen = 1;
                if ((e0 && q0.size() > 0) || (e1 && q1.size() > 0)) begin
                    o = e1 ? q1[0] : q0[0];
                    r = ref_result(o);
                    m_sum = r[W-1:0];
                    m_cout = r[W];
                    m_tag = e1;
                    m_last = e1;
                    m_active = 1;
                    m_age = 1;
                    n_acks++;
                    if (chk_gap && last_ack_cyc >= 0) chk("ack_gap", cyc - last_ack_cyc, W + 2);
                    last_ack_cyc = cyc;
                end
            end else begin
                chk("no_ack_busy", {bus.ack0, bus.ack1, bus.busy}, 32'd1);
                chk("valid", bus.res_valid, (m_age >= W + 1));
                if (m_age >= W + 1) begin
                    chk("result", {bus.res_tag, bus.res_cout, bus.res_sum},
                        {m_tag, m_cout, m_sum});
                    if (bus.res_ready) m_active = 0;
                end
                m_age++;
            end
        end
    end

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk);
            #2;
            if (q0.size() == 0 && q1.size() == 0 && !m_active) done = 1;
        end
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int  base;
        bit  seen;
        rst = 1'b1;
        bus.res_ready = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.a0 = '0;
        bus.b0 = '0;
        bus.a1 = '0;
        bus.b1 = '0;
`ifdef SERIAL_ADD_SUB_EN
        bus.req0_sub = 1'b0;
        bus.req1_sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {bus.busy, bus.res_valid, bus.ack0, bus.ack1, bus.res_sum,
            bus.res_cout, bus.res_tag}, 32'd0);
        rst = 1'b0;

        // Basic adds on each requester, including carry-out cases.
        q0.push_back(mk(8'h5A, 8'h3C, 1'b0));
        wait_idle("add0");
        q1.push_back(mk(8'hFF, 8'h01, 1'b0));
        q1.push_back(mk(8'hFF, 8'hFF, 1'b0));
        wait_idle("add1");

`ifdef SERIAL_ADD_SUB_EN
        q0.push_back(mk(8'h10, 8'h01, 1'b1));
        q0.push_back(mk(8'h00, 8'h01, 1'b1));
        q1.push_back(mk(8'h20, 8'h22, 1'b0));
        wait_idle("sub");
`endif

        // Both requesters held from reset: alternation and WIDTH+2 spacing.
        @(posedge clk);
        #3;
        rst = 1'b1;
        q0.push_back(mk(8'h11, 8'h22, 1'b0));
        q0.push_back(mk(8'h33, 8'h44, 1'b0));
        q1.push_back(mk(8'h55, 8'h66, 1'b0));
        q1.push_back(mk(8'h77, 8'h88, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        base = n_acks;
        chk_gap = 1;
        last_ack_cyc = -1;
        rst = 1'b0;
        wait_idle("rr");
        chk_gap = 0;
        chk("rr_acks", n_acks - base, 4);

        // Consumer stalls in DONE with a request pending on the other side.
        bus.res_ready = 1'b0;
        q0.push_back(mk(8'h40, 8'h41, 1'b0));
        q1.push_back(mk(8'h0F, 8'hF0, 1'b0));
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1;
        end
        if (!seen) chk("stall_valid_timeout", 32'd0, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        wait_idle("stall");

        // Reset in the middle of RUN, after bit 4 has been processed.
        q0.push_back(mk(8'hAA, 8'h55, 1'b0));
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (m_active) seen = 1;
        end
        if (!seen) chk("midrun_ack_timeout", 32'd0, 32'd1);
        repeat (5) @(posedge clk);
        q0.push_back(mk(8'h12, 8'h34, 1'b0));
        q1.push_back(mk(8'h77, 8'h11, 1'b0));
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", {bus.ack0, bus.ack1, bus.busy, bus.res_valid, bus.res_cout,
            bus.res_tag, bus.res_sum}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_idle("after_rst");

        // Random traffic with a randomly stalling consumer.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    if (q0.size() < 3) q0.push_back(rnd_op());
                end else begin
                    if (q1.size() < 3) q1.push_back(rnd_op());
                end
            end
            bus.res_ready = ($urandom_range(0, 2) != 0);
        end
        bus.res_ready = 1'b1;
        wait_idle("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
